keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 matricial keyboard interface. Drives the 2-bit column select, qualifies the debounced "any key" line over several refresh ticks, and captures one 4-bit key code per physical press (code = row*4 + col). It holds the column while a key is down and buffers codes in a small FIFO with a valid/ready output toward the display/consumer logic. It sits between the clock divisor/debouncer/key detector and the key encoding/display path, and replaces the free-running 2-bit column counter.

---
 rtl/keypad_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Column scan sequencer for a 4x4 keypad: settles/releases the debounced key line
// on refresh ticks, captures one {row, col} code per press into a small FIFO.
module keypad_scan_ctrl #(
  parameter int SETTLE_TICKS  = 2,
  parameter int RELEASE_TICKS = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          tick_i,
  input  logic                          key_down_i,
  input  logic [1:0]                    row_i,
  output logic [1:0]                    col_o,
  output logic [3:0]                    key_code_o,
  output logic                          key_valid_o,
  input  logic                          key_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic                          busy_o,
  output logic [1:0]                    state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_SCAN    = 2'd0,
    S_SETTLE  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] cnt_q, cnt_d;
  logic       push;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_SCAN;
      col_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Nothing moves between refresh ticks; the column only advances out of SCAN-bound paths.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        S_SCAN: begin
          if (key_down_i) begin
            state_d = S_SETTLE;
            cnt_d   = 4'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        S_SETTLE: begin
          if (!key_down_i) begin
            state_d = S_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = 4'd0;
          end else if (32'(cnt_q) + 32'd1 >= 32'(SETTLE_TICKS)) begin
            state_d = S_HOLD;
            push    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (!key_down_i) begin
            state_d = S_RELEASE;
            cnt_d   = 4'd1;
          end
        end
        S_RELEASE: begin
          if (key_down_i) begin
            state_d = S_HOLD;
          end else if (32'(cnt_q) == 32'(RELEASE_TICKS)) begin
            state_d = S_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_SCAN;
        end
      endcase
    end
  end

  assign col_o   = col_q;
  assign busy_o  = (state_q != S_SCAN);
  assign state_o = state_q;

  // Handshake: the head entry transfers on any cycle with key_valid_o && key_ready_i;
  // key_code_o holds steady while valid is high and ready is low.
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, overflow_q;
  logic          pop, full, do_push, drop;

  assign pop     = valid_q & key_ready_i;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !pop) count_d = count_q + CW'(1);
    else if (!do_push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= {row_i, col_q};
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      overflow_q <= overflow_q | drop;
    end
  end

  assign key_code_o   = mem[rd_ptr_q];
  assign key_valid_o  = valid_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: scan, settle, hold/release, FIFO overflow and
// simultaneous push/pop, async reset; popped codes are matched against an expected queue.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       tick_i;
  logic       key_down_i;
  logic [1:0] row_i;
  logic [1:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_ready_i;
  logic [2:0] fifo_count_o;
  logic       overflow_o;
  logic       busy_o;
  logic [1:0] state_dbg;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [1:0] exp_col;
  logic [3:0] mon_exp;

  keypad_scan_ctrl #(
    .SETTLE_TICKS (2),
    .RELEASE_TICKS(4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .tick_i      (tick_i),
    .key_down_i  (key_down_i),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (key_ready_i),
    .fifo_count_o(fifo_count_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o),
    .state_o     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: any head transfer the DUT will make at the next edge is compared here.
  always @(negedge clk) begin
    #1;
    if (rst_n_i && key_valid_o && key_ready_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 8'(key_code_o), 8'hff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_code", 8'(key_code_o), 8'(mon_exp));
      end
    end
  end

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    exp_q.delete();
    exp_col = 2'd0;
  endtask

  task automatic tick(input logic key, input logic [1:0] row, input logic rdy);
    @(negedge clk);
    key_down_i  = key;
    row_i       = row;
    key_ready_i = rdy;
    tick_i      = 1'b1;
    @(negedge clk);
    tick_i      = 1'b0;
    key_ready_i = 1'b0;
  endtask

  task automatic press(input logic [3:0] code, input logic pop_now);
    logic [1:0] c;
    logic [1:0] r;
    logic       will_store;
    c = code[1:0];
    r = code[3:2];
    while (exp_col != c) begin
      tick(1'b0, 2'd0, 1'b0);
      exp_col = exp_col + 2'd1;
    end
    check("press_col", 8'(col_o), 8'(exp_col));
    tick(1'b1, r, 1'b0);
    check("press_settle_busy", 8'(busy_o), 8'd1);
    will_store = pop_now || (exp_q.size() < 4);
    tick(1'b1, r, pop_now);
    if (will_store) exp_q.push_back(code);
    repeat (5) tick(1'b0, 2'd0, 1'b0);
    exp_col = exp_col + 2'd1;
    check("press_release_col", 8'(col_o), 8'(exp_col));
    check("press_release_busy", 8'(busy_o), 8'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(negedge clk);
    key_ready_i = 1'b1;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (!key_valid_o) done = 1'b1;
    end
    key_ready_i = 1'b0;
    check("drain_done", 8'(done), 8'd1);
    check("drain_valid", 8'(key_valid_o), 8'd0);
    check("drain_count", 8'(fifo_count_o), 8'd0);
    check("drain_queue_empty", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    tick_i      = 1'b0;
    key_down_i  = 1'b0;
    row_i       = 2'd0;
    key_ready_i = 1'b0;
    do_reset();

    check("rst_col", 8'(col_o), 8'd0);
    check("rst_valid", 8'(key_valid_o), 8'd0);
    check("rst_count", 8'(fifo_count_o), 8'd0);
    check("rst_overflow", 8'(overflow_o), 8'd0);
    check("rst_busy", 8'(busy_o), 8'd0);
    check("rst_code", 8'(key_code_o), 8'd0);

    // Free scan: column steps on every tick and wraps.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 2'd0, 1'b0);
      exp_col = exp_col + 2'd1;
      check("scan_col", 8'(col_o), 8'(exp_col));
      check("scan_busy", 8'(busy_o), 8'd0);
      check("scan_valid", 8'(key_valid_o), 8'd0);
    end

    // Press at column 2, row 1.
    repeat (2) begin
      tick(1'b0, 2'd0, 1'b0);
      exp_col = exp_col + 2'd1;
    end
    check("pre_press_col", 8'(col_o), 8'd2);
    tick(1'b1, 2'd1, 1'b0);
    check("settle_busy", 8'(busy_o), 8'd1);
    check("settle_no_capture", 8'(key_valid_o), 8'd0);
    tick(1'b1, 2'd1, 1'b0);
    exp_q.push_back(4'd6);
    check("cap_valid", 8'(key_valid_o), 8'd1);
    check("cap_count", 8'(fifo_count_o), 8'd1);
    check("cap_code", 8'(key_code_o), 8'd6);

    // Long hold then bounce; column stays until the release run completes.
    repeat (10) tick(1'b1, 2'd1, 1'b0);
    check("hold_col", 8'(col_o), 8'd2);
    check("hold_count", 8'(fifo_count_o), 8'd1);
    tick(1'b0, 2'd0, 1'b0);
    tick(1'b1, 2'd1, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    repeat (3) tick(1'b0, 2'd0, 1'b0);
    check("release_wait_col", 8'(col_o), 8'd2);
    check("release_wait_busy", 8'(busy_o), 8'd1);
    tick(1'b0, 2'd0, 1'b0);
    exp_col = 2'd3;
    check("release_done_col", 8'(col_o), 8'd3);
    check("release_done_busy", 8'(busy_o), 8'd0);
    check("bounce_count", 8'(fifo_count_o), 8'd1);

    // One-tick glitch: no capture, column advances.
    tick(1'b1, 2'd2, 1'b0);
    check("glitch_busy", 8'(busy_o), 8'd1);
    tick(1'b0, 2'd0, 1'b0);
    exp_col = 2'd0;
    check("glitch_col", 8'(col_o), 8'd0);
    check("glitch_busy_after", 8'(busy_o), 8'd0);
    check("glitch_count", 8'(fifo_count_o), 8'd1);
    drain();

    // Five presses into a 4-deep FIFO with no consumer.
    press(4'd0, 1'b0);
    press(4'd5, 1'b0);
    press(4'd10, 1'b0);
    press(4'd15, 1'b0);
    press(4'd3, 1'b0);
    check("ovf_count", 8'(fifo_count_o), 8'd4);
    check("ovf_flag", 8'(overflow_o), 8'd1);
    check("ovf_head", 8'(key_code_o), 8'd0);
    drain();
    check("ovf_sticky", 8'(overflow_o), 8'd1);

    // Full FIFO with a pop on the capture edge: both happen, no overflow.
    do_reset();
    check("rst2_overflow", 8'(overflow_o), 8'd0);
    check("rst2_col", 8'(col_o), 8'd0);
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    press(4'd4, 1'b0);
    check("full_count", 8'(fifo_count_o), 8'd4);
    press(4'd9, 1'b1);
    check("coincide_count", 8'(fifo_count_o), 8'd4);
    check("coincide_overflow", 8'(overflow_o), 8'd0);
    check("coincide_head", 8'(key_code_o), 8'd2);
    drain();

    // Async reset while in HOLD.
    tick(1'b1, 2'd2, 1'b0);
    tick(1'b1, 2'd2, 1'b0);
    check("hold_busy_pre_rst", 8'(busy_o), 8'd1);
    check("hold_count_pre_rst", 8'(fifo_count_o), 8'd1);
    #3;
    rst_n_i = 1'b0;
    #1;
    exp_q.delete();
    check("arst_busy", 8'(busy_o), 8'd0);
    check("arst_col", 8'(col_o), 8'd0);
    check("arst_count", 8'(fifo_count_o), 8'd0);
    check("arst_valid", 8'(key_valid_o), 8'd0);
    check("arst_code", 8'(key_code_o), 8'd0);
    check("arst_overflow", 8'(overflow_o), 8'd0);
    @(negedge clk);
    key_down_i = 1'b0;
    rst_n_i    = 1'b1;
    exp_col    = 2'd0;
    tick(1'b0, 2'd0, 1'b0);
    check("post_rst_col", 8'(col_o), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
